// File: rtl/segre_store_buffer.sv
// segre_store_buffer: in-order store buffer with store-to-load forwarding and cache drain FSM
module segre_store_buffer #(
  parameter int SB_DEPTH        = 4,
  parameter int ADDR_W          = 32,
  parameter int DRAIN_THRESHOLD = SB_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  input  logic                        st_valid_i,
  input  logic [ADDR_W-1:0]           st_addr_i,
  input  logic [31:0]                 st_data_i,
  input  logic [1:0]                  st_type_i,
  output logic                        st_ready_o,
  input  logic                        ld_valid_i,
  input  logic [ADDR_W-1:0]           ld_addr_i,
  input  logic [1:0]                  ld_type_i,
  output logic                        ld_hit_o,
  output logic [31:0]                 ld_data_o,
  output logic                        ld_conflict_o,
  input  logic                        drain_req_i,
  input  logic                        cache_ready_i,
  output logic                        cache_wr_o,
  output logic [ADDR_W-1:0]           cache_addr_o,
  output logic [31:0]                 cache_data_o,
  output logic [1:0]                  cache_type_o,
  output logic                        draining_o,
  output logic [$clog2(SB_DEPTH):0]   count_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, DRAIN} state_e;
  function automatic logic [1:0] off_of(input logic [1:0] a, input logic [1:0] t);
    return t == 2'd0 ? a : t == 2'd1 ? {a[1], 1'b0} : 2'd0;
  endfunction
  function automatic logic [3:0] mask_of(input logic [1:0] a, input logic [1:0] t);
    return t == 2'd0 ? 4'b0001 << a : t == 2'd1 ? 4'b0011 << off_of(a, t) : 4'b1111;
  endfunction
  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [31:0]       lane_q [SB_DEPTH];
  logic [1:0]        type_q [SB_DEPTH];
  logic [3:0]        mask_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q;
  logic [PW-1:0] head, tail, sel, idx;
  logic [CW-1:0] count, count_n;
  state_e state;
  logic push, pop, found, covered, go;
  logic [3:0] st_mask, ld_mask;
  logic [1:0] st_off, ld_off;
  assign st_off  = off_of(st_addr_i[1:0], st_type_i);
  assign st_mask = mask_of(st_addr_i[1:0], st_type_i);
  assign ld_off  = off_of(ld_addr_i[1:0], ld_type_i);
  assign ld_mask = mask_of(ld_addr_i[1:0], ld_type_i);
  assign full_o     = count == CW'(SB_DEPTH);
  assign empty_o    = count == '0;
  assign count_o    = count;
  assign st_ready_o = !full_o;
  assign draining_o = state == DRAIN;
  assign cache_wr_o = draining_o && !empty_o;
  assign push       = st_valid_i && st_ready_o;
  assign pop        = cache_wr_o && cache_ready_i;
  assign count_n    = count + CW'(push) - CW'(pop);
  assign go         = count >= CW'(DRAIN_THRESHOLD) || drain_req_i || (ld_valid_i && ld_conflict_o);
  assign cache_addr_o = addr_q[head];
  assign cache_type_o = type_q[head];
  assign cache_data_o = lane_q[head] >> {off_of(addr_q[head][1:0], type_q[head]), 3'b000};
  // walk oldest to youngest so the last overlapping match is the youngest
  always_comb begin
    sel   = head;
    idx   = head;
    found = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2] && |(mask_q[idx] & ld_mask)) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  assign covered       = (mask_q[sel] & ld_mask) == ld_mask;
  assign ld_hit_o      = ld_valid_i && found && covered;
  assign ld_conflict_o = ld_valid_i && found && !covered;
  assign ld_data_o     = ld_hit_o ? (lane_q[sel] >> {ld_off, 3'b000}) & lanes(ld_mask >> ld_off) : '0;
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      state   <= IDLE;
    end else begin
      if (push) begin
        addr_q[tail]  <= st_addr_i;
        lane_q[tail]  <= (st_data_i << {st_off, 3'b000}) & lanes(st_mask);
        type_q[tail]  <= st_type_i;
        mask_q[tail]  <= st_mask;
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      count <= count_n;
      state <= state == IDLE ? (go ? DRAIN : IDLE) : (count_n == '0 ? IDLE : DRAIN);
    end
  end
endmodule
